// File: rtl/mul_pkg.sv
// ============================================================================
// Module      : mul_pkg
// Description : Shared definitions for the mul arbiter and its clients:
//               FSM state encoding and default requester count / operand
//               width.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package mul_pkg;

    localparam int DEF_N_REQ = 2;
    localparam int DEF_W     = 8;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_ARM   = 3'd2,
        S_WAIT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

endpackage

`default_nettype wire

// File: rtl/mul_arbiter_if.sv
// ============================================================================
// Module      : mul_arbiter_if
// Description : Bus between the arbiter and the shared multiplier.
// Signals     : mul_a_bo/mul_b_bo  operands (W each)
//               mul_start_o        one-cycle start pulse
//               mul_busy_i         multiplier busy flag
//               mul_y_bi           product (2*W)
// Modports    : master - arbiter side, slave - multiplier side
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface mul_arbiter_if #(
    parameter int W = mul_pkg::DEF_W
);
    logic [W-1:0]   mul_a_bo;
    logic [W-1:0]   mul_b_bo;
    logic           mul_start_o;
    logic           mul_busy_i;
    logic [2*W-1:0] mul_y_bi;

    modport master (
        output mul_a_bo, mul_b_bo, mul_start_o,
        input  mul_busy_i, mul_y_bi
    );

    modport slave (
        input  mul_a_bo, mul_b_bo, mul_start_o,
        output mul_busy_i, mul_y_bi
    );
endinterface

`default_nettype wire

// File: rtl/mul_arbiter.sv
// ============================================================================
// Module      : mul_arbiter
// Description : Round-robin arbiter sharing one external multiplier between
//               N_REQ requesters. One transaction at a time:
//               IDLE -> ISSUE -> ARM -> WAIT -> DONE -> IDLE.
// Ports       : clk_i, rst_ni          clock, sync active-low reset
//               req_i[N_REQ]           per-requester request
//               a_bi/b_bi[N_REQ*W]     per-requester operands
//               busy_o[N_REQ]          grant..done, inclusive
//               done_o[N_REQ]          one-cycle result-valid pulse
//               y_bo[N_REQ*2*W]        per-requester product
//               mul_if (master)        shared multiplier bus
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mul_arbiter
    import mul_pkg::*;
#(
    parameter int N_REQ = DEF_N_REQ,
    parameter int W     = DEF_W
) (
    input  wire logic                   clk_i,
    input  wire logic                   rst_ni,
    input  wire logic [N_REQ-1:0]       req_i,
    input  wire logic [N_REQ*W-1:0]     a_bi,
    input  wire logic [N_REQ*W-1:0]     b_bi,
    output logic      [N_REQ-1:0]       busy_o,
    output logic      [N_REQ-1:0]       done_o,
    output logic      [N_REQ*2*W-1:0]   y_bo,
    mul_arbiter_if.master               mul_if
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

    state_t                 state_q,  state_d;
    logic [IW-1:0]          winner_q, winner_d;
    logic [IW-1:0]          last_q,   last_d;
    logic [W-1:0]           opa_q,    opa_d;
    logic [W-1:0]           opb_q,    opb_d;
    logic [N_REQ*2*W-1:0]   y_q,      y_d;
    logic [IW:0]            pick;

    // Circular search starting one past the last grant. Returns
    // {found, index}; the MSB is clear when no request is pending.
    function automatic logic [IW:0] rr_pick(input logic [N_REQ-1:0] req,
                                            input logic [IW-1:0]    last);
        logic          found;
        logic [IW-1:0] idx;
        int            k;
        found = 1'b0;
        idx   = '0;
        for (int i = 1; i <= N_REQ; i++) begin
            k = (int'(last) + i) % N_REQ;
            if (!found && req[k]) begin
                found = 1'b1;
                idx   = IW'(k);
            end
        end
        return {found, idx};
    endfunction

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q  <= S_IDLE;
            winner_q <= '0;
            last_q   <= IW'(N_REQ - 1);
            opa_q    <= '0;
            opb_q    <= '0;
            y_q      <= '0;
        end else begin
            state_q  <= state_d;
            winner_q <= winner_d;
            last_q   <= last_d;
            opa_q    <= opa_d;
            opb_q    <= opb_d;
            y_q      <= y_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        winner_d = winner_q;
        last_d   = last_q;
        opa_d    = opa_q;
        opb_d    = opb_q;
        y_d      = y_q;
        pick     = rr_pick(req_i, last_q);
        case (state_q)
            S_IDLE: begin
                if (pick[IW]) begin
                    winner_d = pick[IW-1:0];
                    last_d   = pick[IW-1:0];
                    opa_d    = a_bi[int'(pick[IW-1:0])*W +: W];
                    opb_d    = b_bi[int'(pick[IW-1:0])*W +: W];
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: state_d = S_ARM;
            S_ARM:   if (mul_if.mul_busy_i)  state_d = S_WAIT;
            S_WAIT:  if (!mul_if.mul_busy_i) state_d = S_DONE;
            S_DONE: begin
                y_d[int'(winner_q)*2*W +: 2*W] = mul_if.mul_y_bi;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Operand registers only load on a grant, so they stay stable for the
    // whole transaction without extra gating.
    assign mul_if.mul_a_bo    = opa_q;
    assign mul_if.mul_b_bo    = opb_q;
    assign mul_if.mul_start_o = (state_q == S_ISSUE);

    // In DONE the winner's slice is forwarded straight from the multiplier so
    // the product is visible in the same cycle as the done pulse; the
    // register holds it afterwards.
    always_comb begin
        busy_o = '0;
        done_o = '0;
        y_bo   = y_q;
        if (state_q != S_IDLE) begin
            busy_o[winner_q] = 1'b1;
        end
        if (state_q == S_DONE) begin
            done_o[winner_q] = 1'b1;
            y_bo[int'(winner_q)*2*W +: 2*W] = mul_if.mul_y_bi;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mul_arbiter.sv
// ============================================================================
// Module      : tb_mul_arbiter
// Description : Directed bench for mul_arbiter with a behavioural multiplier
//               (busy one cycle after start, three busy cycles).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mul_arbiter;

    localparam int N_REQ = 2;
    localparam int W     = 8;

    logic                 clk = 1'b0;
    logic                 rst_n = 1'b0;
    logic [N_REQ-1:0]     req = '0;
    logic [N_REQ*W-1:0]   a = '0;
    logic [N_REQ*W-1:0]   b = '0;
    logic [N_REQ-1:0]     busy;
    logic [N_REQ-1:0]     done;
    logic [N_REQ*2*W-1:0] y;

    mul_arbiter_if #(.W(W)) mif ();

    mul_arbiter #(.N_REQ(N_REQ), .W(W)) dut (
        .clk_i  (clk),
        .rst_ni (rst_n),
        .req_i  (req),
        .a_bi   (a),
        .b_bi   (b),
        .busy_o (busy),
        .done_o (done),
        .y_bo   (y),
        .mul_if (mif)
    );

    always #5 clk = ~clk;

    // Behavioural multiplier
    logic         m_busy = 1'b0;
    logic [15:0]  m_y    = '0;
    logic [15:0]  m_pend = '0;
    logic [2:0]   m_cnt  = '0;

    assign mif.mul_busy_i = m_busy;
    assign mif.mul_y_bi   = m_y;

    always @(posedge clk) begin
        if (mif.mul_start_o) begin
            m_busy <= 1'b1;
            m_cnt  <= 3'd3;
            m_pend <= 16'(mif.mul_a_bo) * 16'(mif.mul_b_bo);
        end else if (m_busy) begin
            if (m_cnt == 3'd1) begin
                m_busy <= 1'b0;
                m_y    <= m_pend;
            end
            m_cnt <= m_cnt - 3'd1;
        end
    end

    // Event monitor
    int n_start = 0;
    int n_done  = 0;
    int glog[$];

    always @(negedge clk) begin
        if (mif.mul_start_o) n_start++;
        for (int k = 0; k < N_REQ; k++) begin
            if (done[k]) begin
                n_done++;
                glog.push_back(k);
            end
        end
    end

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_done(input logic [N_REQ-1:0] mask, output int cycles);
        cycles = 0;
        while (((done & mask) == '0) && (cycles < 40)) begin
            tick();
            cycles++;
        end
        chk("done_timeout", 32'((done & mask) != '0), 32'd1);
    endtask

    int cyc;
    int mark;
    int sd;
    int exp_g;

    initial begin
        // Reset
        rst_n = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        chk("rst_busy",  32'(busy), 0);
        chk("rst_done",  32'(done), 0);
        chk("rst_y",     y, 0);
        chk("rst_start", 32'(mif.mul_start_o), 0);
        chk("rst_opa",   32'(mif.mul_a_bo), 0);

        // Scenario 1: r0 computes 5*7
        n_start = 0;
        a[7:0] = 8'd5; b[7:0] = 8'd7; req = 2'b01;
        tick();
        chk("s1_start",   32'(mif.mul_start_o), 1);
        chk("s1_opa",     32'(mif.mul_a_bo), 5);
        chk("s1_opb",     32'(mif.mul_b_bo), 7);
        chk("s1_busy",    32'(busy), 32'b01);
        a[7:0] = 8'd99;               // ignored after grant
        tick();
        chk("s1_start_off", 32'(mif.mul_start_o), 0);
        chk("s1_opa_hold",  32'(mif.mul_a_bo), 5);
        wait_done(2'b01, cyc);
        chk("s1_latency", cyc, 4);    // ISSUE->DONE is 5 cycles, one spent above
        chk("s1_y",       32'(y[15:0]), 35);
        chk("s1_busy_dn", 32'(busy), 32'b01);
        req = 2'b00;
        tick();
        chk("s1_done_pulse", 32'(done), 0);
        chk("s1_busy_fall",  32'(busy), 0);
        chk("s1_y_hold",     32'(y[15:0]), 35);
        chk("s1_nstart",     n_start, 1);

        // Scenario 2: simultaneous 3*4 and 10*20
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        n_start = 0; glog.delete();
        a = {8'd10, 8'd3}; b = {8'd20, 8'd4}; req = 2'b11;
        wait_done(2'b11, cyc);
        chk("s2_first",  32'(done), 32'b01);
        chk("s2_y0",     32'(y[15:0]), 12);
        req[0] = 1'b0;
        tick();
        wait_done(2'b10, cyc);
        chk("s2_second", 32'(done), 32'b10);
        chk("s2_y1",     32'(y[31:16]), 200);
        chk("s2_y0_keep", 32'(y[15:0]), 12);
        req = 2'b00;
        tick();
        chk("s2_nstart", n_start, 2);

        // Scenario 3: both held for six transactions, expect 0,1,0,1,0,1
        glog.delete();
        a = {8'd4, 8'd2}; b = {8'd5, 8'd3}; req = 2'b11;
        for (int t = 0; t < 6; t++) begin
            exp_g = t % 2;
            wait_done(2'b11, cyc);
            chk("s3_grant", 32'(done), (exp_g == 0) ? 32'b01 : 32'b10);
            chk("s3_y", (exp_g == 0) ? 32'(y[15:0]) : 32'(y[31:16]),
                (exp_g == 0) ? 32'd6 : 32'd20);
            if (t == 5) req = 2'b00;
            tick();
        end
        chk("s3_count", glog.size(), 6);

        // Scenario 4: 255*255
        a[7:0] = 8'd255; b[7:0] = 8'd255; req = 2'b01;
        wait_done(2'b01, cyc);
        chk("s4_y", 32'(y[15:0]), 65025);
        req = 2'b00;
        tick();

        // Scenario 5: reset while in WAIT
        a[7:0] = 8'd3; b[7:0] = 8'd3; req = 2'b01;
        tick();                       // ISSUE
        tick();                       // ARM
        tick();                       // WAIT
        rst_n = 1'b0; req = 2'b00;
        tick();
        rst_n = 1'b1;
        chk("s5_busy",  32'(busy), 0);
        chk("s5_done",  32'(done), 0);
        chk("s5_y",     y, 0);
        chk("s5_start", 32'(mif.mul_start_o), 0);
        chk("s5_opa",   32'(mif.mul_a_bo), 0);
        sd = n_done;
        repeat (10) tick();
        chk("s5_no_done", n_done, sd);
        a[15:8] = 8'd2; b[15:8] = 8'd9; req = 2'b10;
        wait_done(2'b10, cyc);
        chk("s5_y1", 32'(y[31:16]), 18);
        req = 2'b00;
        tick();

        // Scenario 6: r1 pulses req for one cycle during r0's transaction
        mark = glog.size();
        a[7:0] = 8'd6; b[7:0] = 8'd7; a[15:8] = 8'd11; b[15:8] = 8'd11;
        req = 2'b01;
        tick();                       // ISSUE for r0
        req = 2'b11;
        tick();
        req = 2'b01;
        wait_done(2'b01, cyc);
        chk("s6_y0", 32'(y[15:0]), 42);
        req = 2'b00;
        repeat (12) tick();
        chk("s6_ndone", glog.size() - mark, 1);
        chk("s6_y1_keep", 32'(y[31:16]), 18);
        chk("s6_busy", 32'(busy), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/mul_arbiter.md
MUL_ARBITER -- requirements
Module: mul_arbiter

Interface
REQ-001 The block SHALL have parameter N_REQ, default 2, meaning the number of requesters sharing one mul instance (range 2..4).
REQ-002 The block SHALL have parameter W, default 8, meaning the operand width; results are 2*W bits.
REQ-003 clk_i  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_ni  input  1  reset, synchronous, active-low.
REQ-005 req_i  input  N_REQ  per-requester request, held high until that requester's done_o pulse.
REQ-006 a_bi  input  N_REQ*W  per-requester operand A; slice k is bits [k*W +: W].
REQ-007 b_bi  input  N_REQ*W  per-requester operand B, same packing.
REQ-008 busy_o  output  N_REQ  bit k high from the grant of requester k until its done cycle, inclusive.
REQ-009 done_o  output  N_REQ  bit k is a one-cycle pulse when requester k's result is valid.
REQ-010 y_bo  output  N_REQ*2*W  per-requester product, held until that requester's next done.
REQ-011 mul_a_bo / mul_b_bo  output  W each  operands driven to the shared mul.
REQ-012 mul_start_o  output  1  start pulse to mul.
REQ-013 mul_busy_i  input  1  mul busy flag.
REQ-014 mul_y_bi  input  2*W  mul product.

Function
REQ-015 The FSM SHALL have the states IDLE, ISSUE, ARM, WAIT and DONE.
REQ-016 IDLE: if any req_i bit is high, the FSM SHALL select a winner round-robin, latch its a/b slices into the operand registers, record its index, and go to ISSUE; otherwise it stays in IDLE.
REQ-017 Round-robin SHALL search circularly starting at (last_grant+1) mod N_REQ; the first high req_i bit wins; last_grant updates only on a grant.
REQ-018 ISSUE: mul_start_o SHALL be 1 for exactly this one cycle, with the latched operands on mul_a_bo/mul_b_bo; next state is ARM.
REQ-019 ARM: the FSM SHALL wait while mul_busy_i=0; when mul_busy_i=1 it goes to WAIT.
REQ-020 WAIT: the FSM SHALL wait while mul_busy_i=1; when mul_busy_i=0 it goes to DONE.
REQ-021 DONE: the block SHALL capture mul_y_bi into the winner's y_bo slice, pulse done_o[winner] for one cycle, and return to IDLE.
REQ-022 mul_a_bo and mul_b_bo SHALL stay stable from ISSUE through DONE.
REQ-023 mul_start_o SHALL be 0 in every state except ISSUE.
REQ-024 A new grant SHALL NOT occur in the DONE cycle; the earliest re-grant is the following IDLE cycle, giving a minimum gap of 1 idle cycle.
REQ-025 Latency SHALL be: req seen in IDLE at cycle 0; ISSUE at cycle 1; done at (mul busy fall)+1.
REQ-026 req_i and operand changes after the grant SHALL be ignored until done.
REQ-027 A requester that drops req_i before being granted SHALL simply not be served, with no side effect.
REQ-028 Simultaneous requests SHALL be serialized by REQ-017; no requester waits more than N_REQ-1 other transactions.
REQ-029 Products SHALL be unsigned W x W -> 2*W, with no truncation; arithmetic is done by mul only.

Reset
REQ-030 When rst_ni=0 at a clock edge, the block SHALL enter IDLE with busy_o=0, done_o=0, y_bo=0, mul_start_o=0, operand registers=0 and last_grant=N_REQ-1, so requester 0 wins first.
REQ-031 Reset mid-transaction SHALL abandon the transaction with no done_o pulse; any result later produced by mul is ignored.

Structure
REQ-032 The state encoding (IDLE..DONE) and the default N_REQ/W values SHALL live in the shared package mul_pkg for reuse by root-style clients.
REQ-033 The block SHALL instantiate no sub-modules; the mul instance lives in the integration wrapper and connects via the mul_* ports.
REQ-034 The round-robin search SHALL be a combinational function inside the block.

Verification (bench uses the real mul behind the mul_* ports)
REQ-035 Scenario 1: after reset, req_i=01 with a=5, b=7 -> mul_start_o pulses once at cycle 1, y_bo[0]=35, done_o[0] pulses once, busy_o[0] falls after done.
REQ-036 Scenario 2: req_i=11 asserted together after reset, with r0 computing 3*4 and r1 computing 10*20 -> r0 served first (y=12), then r1 (y=200); exactly two mul_start_o pulses.
REQ-037 Scenario 3: both requests held high and each reasserted after its done, for 6 transactions -> grants alternate 0,1,0,1,0,1.
REQ-038 Scenario 4: a=255, b=255 -> y_bo slice=65025 with no truncation.
REQ-039 Scenario 5: rst_ni=0 for 1 cycle while in WAIT -> all outputs 0 and no done_o; a subsequent 2*9 request on r1 yields 18.
REQ-040 Scenario 6: r1 raises req_i for one cycle while r0 is being served, then drops it -> r1 is never granted and its y_bo slice stays unchanged.
